// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: the state encoding,
// the default bit timing and the widths both sides agree on.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 10416;
  localparam int unsigned BIT_CNT_W            = 16;
  localparam int unsigned DATA_BITS            = 8;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_START = 2'd1;
  localparam logic [1:0] STATE_DATA  = 2'd2;
  localparam logic [1:0] STATE_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = STATE_IDLE,
    START = STATE_START,
    DATA  = STATE_DATA,
    STOP  = STATE_STOP
  } uart_state_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit buffer: power-of-two circular FIFO with a show-ahead read port, so a
// pop on an edge consumes the entry that was at the head before that edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from pre-edge state: a push while full is dropped even if
  // the same edge pops, and a freshly pushed entry cannot be popped until the next edge.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffered byte input, LSB-first framing, back-to-back
// frames with no idle gap while the buffer holds data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_byte,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  if (CLKS_PER_BIT >= 65536 || CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLKS_PER_BIT must be in 2..65535");
  end

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e          state_q;
  logic [BIT_CNT_W-1:0] clk_cnt_q;
  logic [BIT_CNT_W-1:0] clk_cnt_d;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;
  logic                 tx_serial_q;
  logic                 tx_done_q;

  logic                 bit_end;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid),
    .data_i  (tx_byte),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_end = (clk_cnt_q == BIT_LAST);

  always_comb begin
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + BIT_CNT_W'(1);
    // Load a new frame from idle, or chain straight from the last stop cycle.
    fifo_pop  = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && bit_end));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_serial_q <= 1'b1;
          clk_cnt_q   <= '0;
          if (fifo_pop) begin
            shift_q     <= fifo_data;
            bit_idx_q   <= '0;
            tx_serial_q <= 1'b0;
            state_q     <= START;
          end
        end
        START: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end) begin
            tx_serial_q <= shift_q[0];
            state_q     <= DATA;
          end
        end
        DATA: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              tx_serial_q <= 1'b1;
              state_q     <= STOP;
            end else begin
              bit_idx_q   <= bit_idx_q + 3'd1;
              shift_q     <= {1'b0, shift_q[7:1]};
              tx_serial_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end) begin
            tx_done_q <= 1'b1;
            if (fifo_pop) begin
              shift_q     <= fifo_data;
              bit_idx_q   <= '0;
              tx_serial_q <= 1'b0;
              state_q     <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          tx_serial_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_done   = tx_done_q;
  assign tx_busy   = (state_q != IDLE);
  assign tx_ready  = !fifo_full;

endmodule
